fifo_bit_reader: RTL and testbench

FIFO_BIT_READER -- requirements
Module: fifo_bit_reader

---
 rtl/toce_pkg.sv | 12 +
 rtl/fifo_bit_reader.sv | 89 ++++++++
 tb/tb_fifo_bit_reader.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/toce_pkg.sv
// Shared constants for the bit reader: byte width, max bits per request,
// buffer width and count width.
package toce_pkg;

  localparam int TOCE_DWIDTH = 8;
  localparam int TOCE_MAXB   = 15;
  localparam int TOCE_BUF_W  = TOCE_MAXB + TOCE_DWIDTH;
  localparam int TOCE_CNT_W  = 5;

  typedef logic [TOCE_CNT_W-1:0] cnt_t;

endpackage : toce_pkg

// File: rtl/fifo_bit_reader.sv
// Pulls bytes from a FIFO into an LSB-first bit buffer and hands out
// variable-length bit fields (0..MAXB bits) on request/acknowledge.
module fifo_bit_reader
  import toce_pkg::*;
#(
  parameter int DWIDTH = TOCE_DWIDTH,
  parameter int MAXB   = TOCE_MAXB
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_one_available_i,
  input  logic [DWIDTH-1:0] fifo_data_i,
  output logic              fifo_re_o,
  input  logic              req_i,
  input  logic [3:0]        bitload_i,
  input  logic              flush_i,
  output logic              ack_o,
  output logic [MAXB-1:0]   bits_o,
  output logic [4:0]        bit_count_o
);

  localparam int BUF_W = MAXB + DWIDTH;
  localparam int CNT_W = TOCE_CNT_W;

  logic [BUF_W-1:0] sbuf_q, sbuf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_pend_q;
  logic             ack_q, ack_d;
  logic [MAXB-1:0]  bits_q, bits_d;

  logic [CNT_W-1:0] look_s;
  logic             accept_s;
  logic [BUF_W-1:0] shifted_s;
  logic [CNT_W-1:0] base_s;

  // Count an in-flight byte as already present so the buffer never overflows.
  assign look_s    = cnt_q + (rd_pend_q ? CNT_W'(DWIDTH) : CNT_W'(0));
  assign fifo_re_o = fifo_one_available_i & ~flush_i & ~reset & (look_s <= CNT_W'(MAXB));
  assign accept_s  = req_i & ~ack_q & ~flush_i & (cnt_q >= CNT_W'(bitload_i));

  always_comb begin
    shifted_s = sbuf_q;
    base_s    = cnt_q;
    bits_d    = bits_q;
    ack_d     = accept_s;
    sbuf_d    = sbuf_q;
    cnt_d     = cnt_q;
    if (accept_s) begin
      shifted_s = sbuf_q >> bitload_i;
      base_s    = cnt_q - CNT_W'(bitload_i);
      bits_d    = sbuf_q[MAXB-1:0] & ~({MAXB{1'b1}} << bitload_i);
    end else begin
      shifted_s = sbuf_q;
      base_s    = cnt_q;
    end
    // Bits above cnt are always zero, so the new byte can simply be OR-ed in.
    if (flush_i) begin
      sbuf_d = '0;
      cnt_d  = CNT_W'(0);
    end else if (rd_pend_q) begin
      sbuf_d = shifted_s | (BUF_W'(fifo_data_i) << base_s);
      cnt_d  = base_s + CNT_W'(DWIDTH);
    end else begin
      sbuf_d = shifted_s;
      cnt_d  = base_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sbuf_q    <= '0;
      cnt_q     <= CNT_W'(0);
      rd_pend_q <= 1'b0;
      ack_q     <= 1'b0;
      bits_q    <= '0;
    end else begin
      sbuf_q    <= sbuf_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= fifo_re_o;
      ack_q     <= ack_d;
      bits_q    <= bits_d;
    end
  end

  assign ack_o       = ack_q;
  assign bits_o      = bits_q;
  assign bit_count_o = cnt_q;

endmodule : fifo_bit_reader

// File: tb/tb_fifo_bit_reader.sv
// Directed bench for fifo_bit_reader with a small behavioural FIFO model.
module tb_fifo_bit_reader;

  logic        clk;
  logic        reset;
  logic        fifo_avail;
  logic [7:0]  fifo_data;
  logic        fifo_re;
  logic        req;
  logic [3:0]  bitload;
  logic        flush;
  logic        ack;
  logic [14:0] bits;
  logic [4:0]  count;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:31];
  int wp = 0;
  int rp = 0;
  int rd_total = 0;

  fifo_bit_reader dut (
    .clk                  (clk),
    .reset                (reset),
    .fifo_one_available_i (fifo_avail),
    .fifo_data_i          (fifo_data),
    .fifo_re_o            (fifo_re),
    .req_i                (req),
    .bitload_i            (bitload),
    .flush_i              (flush),
    .ack_o                (ack),
    .bits_o               (bits),
    .bit_count_o          (count)
  );

  always #5 clk = ~clk;

  assign fifo_avail = (wp != rp);

  // FIFO model: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (fifo_re) begin
      fifo_data <= mem[rp[4:0]];
      rp        <= rp + 1;
      rd_total  <= rd_total + 1;
    end
  end

  task automatic push(input logic [7:0] v);
    mem[wp[4:0]] = v;
    wp = wp + 1;
  endtask

  task automatic wait_ack(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (fifo_re !== 1'b0) begin errors++; $display("FAIL reset_re got %0b want 0", fifo_re); end
    end
    checks++;
    if (ack !== 1'b0 || bits !== 15'h0000 || count !== 5'd0) begin
      errors++; $display("FAIL reset_outputs got ack=%0b bits=%h cnt=%0d want 0/0/0", ack, bits, count);
    end
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (fifo_re !== 1'b0 || ack !== 1'b0 || count !== 5'd0) begin
        errors++; $display("FAIL idle_empty got re=%0b ack=%0b cnt=%0d want 0/0/0", fifo_re, ack, count);
      end
    end
  endtask

  task automatic test_basic();
    bit ok;
    int r0;
    r0 = rd_total;
    push(8'hAA);
    req = 1'b1; bitload = 4'd3;
    wait_ack(10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_ack3 got no ack want ack"); end
    checks++;
    if (bits !== 15'h0002 || count !== 5'd5) begin
      errors++; $display("FAIL basic_bits3 got bits=%h cnt=%0d want 0002/5", bits, count);
    end
    checks++;
    if (rd_total - r0 !== 1) begin errors++; $display("FAIL basic_reads got %0d want 1", rd_total - r0); end
    bitload = 4'd5;
    @(negedge clk);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL ack_pulse got %0b want 0", ack); end
    wait_ack(5, ok);
    checks++;
    if (!ok || bits !== 15'h0015 || count !== 5'd0) begin
      errors++; $display("FAIL basic_bits5 got ok=%0b bits=%h cnt=%0d want 1/0015/0", ok, bits, count);
    end
    req = 1'b0;
  endtask

  task automatic test_two_bytes();
    bit ok;
    int r0;
    r0 = rd_total;
    push(8'h34); push(8'h12);
    req = 1'b1; bitload = 4'd15;
    #1;
    checks++;
    if (fifo_re !== 1'b1) begin errors++; $display("FAIL b2b_re0 got %0b want 1", fifo_re); end
    @(negedge clk);
    checks++;
    if (fifo_re !== 1'b1) begin errors++; $display("FAIL b2b_re1 got %0b want 1", fifo_re); end
    wait_ack(10, ok);
    checks++;
    if (!ok || bits !== 15'h1234 || count !== 5'd1) begin
      errors++; $display("FAIL two_bytes got ok=%0b bits=%h cnt=%0d want 1/1234/1", ok, bits, count);
    end
    checks++;
    if (rd_total - r0 !== 2) begin errors++; $display("FAIL two_reads got %0d want 2", rd_total - r0); end
    req = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (count !== 5'd0) begin errors++; $display("FAIL flush_clear got %0d want 0", count); end
  endtask

  task automatic test_starve();
    bit ok;
    bit bad;
    bad = 1'b0;
    req = 1'b1; bitload = 4'd4;
    repeat (20) begin
      @(negedge clk);
      if (ack !== 1'b0 || bits !== 15'h1234 || fifo_re !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL starve_hold got ack=%0b bits=%h want 0/1234", ack, bits); end
    push(8'h5C);
    wait_ack(10, ok);
    checks++;
    if (!ok || bits !== 15'h000C || count !== 5'd4) begin
      errors++; $display("FAIL starve_serve got ok=%0b bits=%h cnt=%0d want 1/000c/4", ok, bits, count);
    end
    req = 1'b0;
  endtask

  task automatic test_zero_flush();
    bit ok;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    push(8'hAA);
    req = 1'b1; bitload = 4'd3;
    wait_ack(10, ok);
    checks++;
    if (!ok || count !== 5'd5) begin errors++; $display("FAIL zero_setup got ok=%0b cnt=%0d want 1/5", ok, count); end
    req = 1'b0;
    @(negedge clk);
    req = 1'b1; bitload = 4'd0;
    @(negedge clk);
    checks++;
    if (ack !== 1'b1 || bits !== 15'h0000 || count !== 5'd5) begin
      errors++; $display("FAIL zero_load got ack=%0b bits=%h cnt=%0d want 1/0000/5", ack, bits, count);
    end
    req = 1'b0;
    @(negedge clk);
    push(8'hFF);
    #1;
    checks++;
    if (fifo_re !== 1'b1) begin errors++; $display("FAIL flight_re got %0b want 1", fifo_re); end
    @(negedge clk);
    flush = 1'b1;
    push(8'h70);
    #1;
    checks++;
    if (fifo_re !== 1'b0) begin errors++; $display("FAIL flush_re got %0b want 0", fifo_re); end
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (count !== 5'd0) begin errors++; $display("FAIL flush_discard got %0d want 0", count); end
    req = 1'b1; bitload = 4'd8;
    wait_ack(10, ok);
    checks++;
    if (!ok || bits !== 15'h0070 || count !== 5'd0) begin
      errors++; $display("FAIL post_flush got ok=%0b bits=%h cnt=%0d want 1/0070/0", ok, bits, count);
    end
    req = 1'b0;
  endtask

  task automatic test_fill_concurrent();
    bit ok;
    bit bad;
    int r0;
    r0 = rd_total;
    bad = 1'b0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    #1;
    if (fifo_re !== 1'b1) bad = 1'b1;
    @(negedge clk);
    if (fifo_re !== 1'b1) bad = 1'b1;
    repeat (9) begin
      @(negedge clk);
      if (fifo_re !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL fill_re_pattern got re=%0b want 1,1 then 0", fifo_re); end
    checks++;
    if (count !== 5'd16 || rd_total - r0 !== 2) begin
      errors++; $display("FAIL fill_count got cnt=%0d reads=%0d want 16/2", count, rd_total - r0);
    end
    req = 1'b1; bitload = 4'd1;
    wait_ack(5, ok);
    checks++;
    if (!ok || bits !== 15'h0001 || count !== 5'd15 || fifo_re !== 1'b1) begin
      errors++; $display("FAIL fill_consume got ok=%0b bits=%h cnt=%0d re=%0b want 1/0001/15/1", ok, bits, count, fifo_re);
    end
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (count !== 5'd23 || fifo_re !== 1'b0) begin
      errors++; $display("FAIL fill_max got cnt=%0d re=%0b want 23/0", count, fifo_re);
    end
    req = 1'b1; bitload = 4'd8;
    wait_ack(5, ok);
    checks++;
    if (!ok || bits !== 15'h0008 || count !== 5'd15) begin
      errors++; $display("FAIL conc_step1 got ok=%0b bits=%h cnt=%0d want 1/0008/15", ok, bits, count);
    end
    bitload = 4'd7;
    wait_ack(5, ok);
    checks++;
    if (!ok || bits !== 15'h0011 || count !== 5'd16) begin
      errors++; $display("FAIL conc_load_consume got ok=%0b bits=%h cnt=%0d want 1/0011/16", ok, bits, count);
    end
    bitload = 4'd15;
    wait_ack(5, ok);
    checks++;
    if (!ok || bits !== 15'h4433 || count !== 5'd1) begin
      errors++; $display("FAIL conc_place got ok=%0b bits=%h cnt=%0d want 1/4433/1", ok, bits, count);
    end
    req = 1'b0;
  endtask

  task automatic test_reset_midflight();
    bit bad;
    bad = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    push(8'h99);
    #1;
    checks++;
    if (fifo_re !== 1'b1) begin errors++; $display("FAIL mid_re got %0b want 1", fifo_re); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (fifo_re !== 1'b0) begin errors++; $display("FAIL reset_gate_re got %0b want 0", fifo_re); end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      if (count !== 5'd0 || ack !== 1'b0 || bits !== 15'h0000) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL reset_discard got cnt=%0d ack=%0b bits=%h want 0/0/0", count, ack, bits);
    end
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    req = 1'b0;
    bitload = 4'd0;
    flush = 1'b0;
    test_reset();
    test_basic();
    test_two_bytes();
    test_starve();
    test_zero_flush();
    test_fill_concurrent();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fifo_bit_reader
